// File: rtl/time_counter_if.sv
// Key inputs and BCD display/status outputs of the time-of-day counter; pm exists only when HOUR12_EN is defined.
interface time_counter_if;
  logic       key_mode;
  logic       key_inc;
  logic [3:0] data0;
  logic [3:0] data1;
  logic [3:0] data2;
  logic [3:0] data3;
  logic [3:0] data4;
  logic [3:0] data5;
  logic [1:0] mode;
  logic       tick_1hz;
`ifdef HOUR12_EN
  logic       pm;

  modport master (output key_mode, key_inc,
                  input  data0, data1, data2, data3, data4, data5, mode, tick_1hz, pm);
  modport slave  (input  key_mode, key_inc,
                  output data0, data1, data2, data3, data4, data5, mode, tick_1hz, pm);
`else
  modport master (output key_mode, key_inc,
                  input  data0, data1, data2, data3, data4, data5, mode, tick_1hz);
  modport slave  (input  key_mode, key_inc,
                  output data0, data1, data2, data3, data4, data5, mode, tick_1hz);
`endif
endinterface

// File: rtl/time_counter.sv
// BCD HH:MM:SS counter with debounced mode/inc set keys; HOUR12_EN selects 12-hour operation with a pm flag.
// Digits update one clk after tick_1hz; a key acts DEBOUNCE_CYC+2 clks after its level settles; no backpressure.
module time_counter #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic          clk,
  input  logic          rstn,
  time_counter_if.slave io
);
  localparam int              PS_W    = $clog2(CLK_HZ + 1);
  localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
`ifdef HOUR12_EN
  localparam logic [7:0] HR_LAST = 8'h12;
  localparam logic [7:0] HR_WRAP = 8'h01;
  localparam logic [7:0] HR_RST  = 8'h12;
`else
  localparam logic [7:0] HR_LAST = 8'h23;
  localparam logic [7:0] HR_WRAP = 8'h00;
  localparam logic [7:0] HR_RST  = 8'h00;
`endif

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

  // Key index 0 is mode, 1 is inc.
  logic [1:0]           w_raw;
  logic [1:0]           r_sync1;
  logic [1:0]           r_sync2;
  logic [1:0]           r_deb;
  logic [1:0][DB_W-1:0] r_db_cnt;
  logic [1:0]           w_press;

  state_t          r_state;
  logic [PS_W-1:0] r_presc;
  logic [7:0]      r_hr;
  logic [7:0]      r_min;
  logic [7:0]      r_sec;
  logic            w_tick;
  logic            w_mode_ev;
  logic            w_inc_ev;
`ifdef HOUR12_EN
  logic            r_pm;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last,
                                         input logic [7:0] wrap);
    if (v == last)
      return wrap;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_raw = {io.key_inc, io.key_mode};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_deb    <= 2'b11;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_deb[k]    <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // A press fires in the clk the debounced level commits to 0.
  always_comb begin
    w_press = '0;
    for (int k = 0; k < 2; k++)
      w_press[k] = r_deb[k] & ~r_sync2[k] & (r_db_cnt[k] == DB_LAST);
  end

  assign w_mode_ev = w_press[0];
  assign w_inc_ev  = w_press[1] & ~w_press[0];
  assign w_tick    = (r_state == RUN) && (r_presc == PS_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
      r_presc <= '0;
      r_hr    <= HR_RST;
      r_min   <= '0;
      r_sec   <= '0;
`ifdef HOUR12_EN
      r_pm    <= 1'b0;
`endif
    end else begin
      if (w_tick) begin
        r_sec <= bcd_inc(r_sec, 8'h59, 8'h00);
        if (r_sec == 8'h59) begin
          r_min <= bcd_inc(r_min, 8'h59, 8'h00);
          if (r_min == 8'h59) begin
            r_hr <= bcd_inc(r_hr, HR_LAST, HR_WRAP);
`ifdef HOUR12_EN
            if (r_hr == 8'h11)
              r_pm <= ~r_pm;
`endif
          end
        end
      end

      if (r_state == RUN && !w_mode_ev)
        r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      else
        r_presc <= '0;

      // Mode has priority over a same-clk inc; a tick never coincides with a set-state edit.
      if (w_mode_ev) begin
        case (r_state)
          RUN:     r_state <= SET_HR;
          SET_HR:  r_state <= SET_MIN;
          default: begin
            r_state <= RUN;
            r_sec   <= '0;
          end
        endcase
      end else if (w_inc_ev) begin
        if (r_state == SET_HR) begin
          r_hr <= bcd_inc(r_hr, HR_LAST, HR_WRAP);
`ifdef HOUR12_EN
          if (r_hr == 8'h11)
            r_pm <= ~r_pm;
`endif
        end else if (r_state == SET_MIN) begin
          r_min <= bcd_inc(r_min, 8'h59, 8'h00);
        end
      end
    end
  end

  assign io.data0    = r_hr[7:4];
  assign io.data1    = r_hr[3:0];
  assign io.data2    = r_min[7:4];
  assign io.data3    = r_min[3:0];
  assign io.data4    = r_sec[7:4];
  assign io.data5    = r_sec[3:0];
  assign io.mode     = r_state;
  assign io.tick_1hz = w_tick;
`ifdef HOUR12_EN
  assign io.pm       = r_pm;
`endif
endmodule

// File: tb/tb_time_counter.sv
// Randomized scoreboard bench for time_counter: a seconds-of-day reference model predicts every output event.
module tb_time_counter;
  localparam int CLK_HZ   = 10;
  localparam int DEB      = 4;
  localparam int PRESS_LO = DEB + 2;
  localparam int DAY      = 86400;
`ifdef HOUR12_EN
  localparam int HR_PRE = 11;
`else
  localparam int HR_PRE = 23;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  time_counter_if io ();

  time_counter #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io)
  );

  typedef struct {
    bit is_tick;
    int secs;
    int mode;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  // Reference model: time as seconds of day, keys as delayed raw samples with a stability count.
  int m_secs;
  int m_mode;
  int m_run_clks;
  bit m_deb[2];
  int m_cnt[2];
  bit m_q_mode[$];
  bit m_q_inc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_digits(input int secs);
    int hh = secs / 3600;
    int mm = (secs / 60) % 60;
    int ss = secs % 60;
`ifdef HOUR12_EN
    hh = (hh % 12 == 0) ? 12 : hh % 12;
`endif
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {io.data0, io.data1, io.data2, io.data3, io.data4, io.data5};
  endfunction

  function automatic logic [26:0] snap();
    logic p = 1'b0;
`ifdef HOUR12_EN
    p = io.pm;
`endif
    return {dut_digits(), io.mode, p};
  endfunction

  task automatic model_reset();
    m_secs     = 0;
    m_mode     = 0;
    m_run_clks = 0;
    m_deb      = '{1'b1, 1'b1};
    m_cnt      = '{0, 0};
    m_q_mode   = '{1'b1, 1'b1};
    m_q_inc    = '{1'b1, 1'b1};
  endtask

  // Advances the model over one rising edge, given the key levels sampled at that edge.
  task automatic model_edge(input bit km, input bit ki);
    bit seen[2];
    bit ev[2];
    bit tick;
    int old_secs = m_secs;
    int old_mode = m_mode;
    m_q_mode.push_back(km);
    seen[0] = m_q_mode.pop_front();
    m_q_inc.push_back(ki);
    seen[1] = m_q_inc.pop_front();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      m_cnt[k] = (seen[k] != m_deb[k]) ? m_cnt[k] + 1 : 0;
      if (m_cnt[k] == DEB) begin
        m_deb[k] = seen[k];
        m_cnt[k] = 0;
        ev[k]    = !seen[k];
      end
    end
    tick = (m_mode == 0) && (m_run_clks % CLK_HZ == CLK_HZ - 1);
    if (tick) begin
      sb.push_back('{1'b1, 0, 0});
      m_secs = (m_secs + 1) % DAY;
    end
    if (ev[0]) begin
      m_mode     = (m_mode + 1) % 3;
      m_run_clks = 0;
      if (m_mode == 0)
        m_secs = m_secs - m_secs % 60;
    end else begin
      if (m_mode == 0)
        m_run_clks++;
      if (ev[1] && m_mode == 1)
        m_secs = (m_secs + 3600) % DAY;
      else if (ev[1] && m_mode == 2)
        m_secs = m_secs - m_secs % 3600 + (((m_secs / 60) + 1) % 60) * 60 + m_secs % 60;
    end
    if (m_secs != old_secs || m_mode != old_mode)
      sb.push_back('{1'b0, m_secs, m_mode});
  endtask

  task automatic step(input bit km, input bit ki);
    @(negedge clk);
    io.key_mode = km;
    io.key_inc  = ki;
    model_edge(km, ki);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1);
  endtask

  task automatic press(input bit m, input bit i);
    repeat (PRESS_LO) step(!m, !i);
    idle(PRESS_LO);
  endtask

  task automatic do_reset();
    io.key_mode = 1'b1;
    io.key_inc  = 1'b1;
    #3;
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    model_reset();
    check("rst_digits", dut_digits(), exp_digits(0));
    check("rst_mode", io.mode, 0);
    check("rst_tick", io.tick_1hz, 0);
`ifdef HOUR12_EN
    check("rst_pm", io.pm, 0);
`endif
    repeat (2) @(negedge clk);
    sb.delete();
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    model_edge(1'b1, 1'b1);
  endtask

  initial begin : monitor
    logic [26:0] prev;
    logic [26:0] cur;
    exp_t        r;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = snap();
      if (!mon_en) begin
        prev = cur;
      end else begin
        if (cur !== prev) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_change: got %0h after %0h with no event due at %0t", cur, prev, $time);
          end else begin
            r = sb.pop_front();
            check("event_kind_change", 0, r.is_tick);
            if (!r.is_tick) begin
              check("digits", dut_digits(), exp_digits(r.secs));
              check("mode", io.mode, r.mode);
`ifdef HOUR12_EN
              check("pm", io.pm, (r.secs >= DAY / 2) ? 1 : 0);
`endif
            end
          end
          prev = cur;
        end
        if (io.tick_1hz !== 1'b0) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_tick: got tick_1hz=%b expected 0 at %0t", io.tick_1hz, $time);
          end else begin
            r = sb.pop_front();
            check("event_kind_tick", 1, r.is_tick);
          end
        end
      end
    end
  end

  initial begin : stimulus
    io.key_mode = 1'b1;
    io.key_inc  = 1'b1;
    do_reset();
    idle(25);

    // Preload hh:59 then run through the full-day (or noon) rollover.
    press(1'b1, 1'b0);
    repeat (HR_PRE) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    idle(60 * CLK_HZ + 15);

    // Bounce on inc in SET_HR: only the final stable low counts.
    press(1'b1, 1'b0);
    repeat (3) begin
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
    end
    repeat (DEB) step(1'b1, 1'b0);
    idle(2 * PRESS_LO);

    // Frozen time, hour and minute wrap, simultaneous mode+inc, return to RUN.
    idle(50);
    repeat (25) press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    repeat (61) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    idle(3 * CLK_HZ);

    repeat (40) begin
      case ($urandom_range(0, 4))
        0:       idle($urandom_range(1, 3 * CLK_HZ));
        1:       press(1'b1, 1'b0);
        2:       press(1'b0, 1'b1);
        3:       press(1'b1, 1'b1);
        default: repeat ($urandom_range(2, 12))
                   step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end

    // Asynchronous reset while editing minutes.
    idle(PRESS_LO);
    for (int i = 0; i < 6 && m_mode != 2; i++)
      press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    do_reset();
    idle(30);

    // Park in SET_HR so no event is outstanding when the queue is inspected.
    press(1'b1, 1'b0);
    idle(10);
    #4;
    check("pending_events", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
